mult_div_ctrl: RTL and testbench

Sequencer for the multicycle CPU's iterative multiply/divide unit. Accepts a MULT/DIV request from the main control unit, drives the MDSrcB operand-select line (register B or memory data), waits for the memory operand when needed, and checks for divide-by-zero. It then starts the iterative unit, counts its fixed latency, pulses the HI/LO write enable and reports completion. It sits between the main control FSM and the MDSrcB mux / mult-div / HI-LO datapath.

---
 rtl/mult_div_ctrl.sv | 131 +++++++++++++
 tb/tb_mult_div_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// Sequencer for the iterative multiply/divide unit: operand select, memory wait,
// divide-by-zero trap (enabled by macro MD_DIVZERO_TRAP_EN), latency count, HI/LO write.
module mult_div_ctrl #(
  parameter int LATENCY  = 32,
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_is_div,
  input  logic        op_src_mem,
  input  logic [31:0] mdsrcb_value,
  output logic        mdsrcb_sel,
  output logic        mem_read,
  output logic        md_op,
  output logic        md_start,
  output logic        hilo_write,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    EXC   = 3'd6
  } state_t;

`ifdef MD_DIVZERO_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);
  localparam logic [7:0] MW_LOAD  = 8'(MEM_WAIT - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       trap;

  // With the trap disabled, CHECK always proceeds to RUN and EXC is unreachable.
  assign trap      = TRAP_EN && md_op && (mdsrcb_value == 32'd0);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      mdsrcb_sel <= 1'b0;
      mem_read   <= 1'b0;
      md_op      <= 1'b0;
      md_start   <= 1'b0;
      hilo_write <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      md_start   <= 1'b0;
      hilo_write <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      case (state)
        IDLE: begin
          if (op_start) begin
            md_op      <= op_is_div;
            mdsrcb_sel <= op_src_mem;
            busy       <= 1'b1;
            if (op_src_mem) begin
              state    <= FETCH;
              cnt      <= MW_LOAD;
              mem_read <= 1'b1;
            end else begin
              state <= CHECK;
            end
          end
        end
        FETCH: begin
          if (cnt == 8'd0) begin
            state    <= CHECK;
            mem_read <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        CHECK: begin
          if (trap) begin
            state    <= EXC;
            div_zero <= 1'b1;
          end else begin
            state    <= RUN;
            cnt      <= LAT_LOAD;
            md_start <= 1'b1;
          end
        end
        RUN: begin
          // Counter holds the remaining RUN cycles after the current one.
          if (cnt == 8'd0) begin
            state      <= WRITE;
            hilo_write <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        WRITE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE, EXC: begin
          state      <= IDLE;
          busy       <= 1'b0;
          md_op      <= 1'b0;
          mdsrcb_sel <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          md_op      <= 1'b0;
          mdsrcb_sel <= 1'b0;
          mem_read   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Randomized self-checking bench for mult_div_ctrl; per-cycle output vectors are
// predicted from the cycle-numbered timing rules and compared through an expected queue.
module tb_mult_div_ctrl;

  localparam int LATENCY  = 32;
  localparam int MEM_WAIT = 1;

`ifdef MD_DIVZERO_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        op_start;
  logic        op_is_div;
  logic        op_src_mem;
  logic [31:0] mdsrcb_value;
  logic        mdsrcb_sel;
  logic        mem_read;
  logic        md_op;
  logic        md_start;
  logic        hilo_write;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [2:0]  dbg_state;

  int vectors;
  int miscompares;
  logic [7:0] exp_q[$];

  mult_div_ctrl #(.LATENCY(LATENCY), .MEM_WAIT(MEM_WAIT)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_is_div(op_is_div),
    .op_src_mem(op_src_mem), .mdsrcb_value(mdsrcb_value), .mdsrcb_sel(mdsrcb_sel),
    .mem_read(mem_read), .md_op(md_op), .md_start(md_start), .hilo_write(hilo_write),
    .busy(busy), .done(done), .div_zero(div_zero), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {mdsrcb_sel, mem_read, md_op, md_start, hilo_write, busy, done, div_zero};
  endfunction

  // Reference model: last busy cycle of a request accepted at edge E0
  function automatic int op_last(bit div, bit mem, logic [31:0] val);
    int f = mem ? MEM_WAIT : 0;
    if (TRAP && div && val == 32'd0) return 2 + f;
    return LATENCY + 3 + f;
  endfunction

  // Reference model: expected {sel,mem_read,md_op,md_start,hilo,busy,done,div_zero} in cycle n
  function automatic logic [7:0] exp_vec(int n, bit div, bit mem, logic [31:0] val);
    int  f    = mem ? MEM_WAIT : 0;
    bit  exc  = TRAP && div && val == 32'd0;
    int  last = op_last(div, mem, val);
    bit  act  = (n >= 1) && (n <= last);
    logic [7:0] v;
    v[7] = act && mem;
    v[6] = mem && n >= 1 && n <= f;
    v[5] = act && div;
    v[4] = !exc && n == 2 + f;
    v[3] = !exc && n == LATENCY + 2 + f;
    v[2] = act;
    v[1] = !exc && n == last;
    v[0] = exc && n == last;
    return v;
  endfunction

  function automatic void check_cycle(string name, int n);
    logic [7:0] e;
    e = exp_q.pop_front();
    vectors++;
    if (outs() !== e) begin
      miscompares++;
      $display("FAIL %s cycle %0d: outputs %b, required %b", name, n, outs(), e);
    end
  endfunction

  // Driver: issue one request and check cycles 1..last+1; noise toggles op_start while busy.
  task automatic run_op(string name, bit div, bit mem, logic [31:0] val, bit noise);
    int last = op_last(div, mem, val);
    for (int n = 1; n <= last + 1; n++) exp_q.push_back(exp_vec(n, div, mem, val));
    op_is_div    = div;
    op_src_mem   = mem;
    mdsrcb_value = val;
    op_start     = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    for (int n = 1; n <= last + 1; n++) begin
      check_cycle(name, n);
      if (n <= last) begin
        if (noise) begin
          op_start   = 1'($urandom_range(0, 1));
          op_is_div  = 1'($urandom_range(0, 1));
          op_src_mem = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
      end
    end
    op_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_start = 1'b1; op_is_div = 1'b1; op_src_mem = 1'b1;
    mdsrcb_value = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (outs() !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_hold: outputs %b, required %b", outs(), 8'd0);
    end
    reset = 1'b0; op_start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if (outs() !== 8'd0) begin
        miscompares++;
        $display("FAIL reset_idle: outputs %b, required %b", outs(), 8'd0);
      end
    end
  endtask

  task automatic test_mult_reg();
    run_op("mult_reg", 1'b0, 1'b0, $urandom, 1'b0);
  endtask

  task automatic test_div_mem();
    run_op("div_mem", 1'b1, 1'b1, 32'd7, 1'b0);
  endtask

  task automatic test_div_zero();
    run_op("div_zero_reg", 1'b1, 1'b0, 32'd0, 1'b0);
    run_op("div_zero_mem", 1'b1, 1'b1, 32'd0, 1'b0);
  endtask

  task automatic test_start_during_run();
    run_op("start_noise", 1'b0, 1'b0, 32'd5, 1'b1);
    run_op("after_noise", 1'b1, 1'b0, 32'd9, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    int cut = 11;  // tenth RUN cycle of a register-source request
    for (int n = 1; n <= cut; n++) exp_q.push_back(exp_vec(n, 1'b0, 1'b0, 32'd3));
    op_is_div = 1'b0; op_src_mem = 1'b0; mdsrcb_value = 32'd3; op_start = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    for (int n = 1; n <= cut; n++) begin
      check_cycle("reset_mid_run", n);
      if (n < cut) begin
        @(posedge clk); #1;
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if (outs() !== 8'd0 || dbg_state !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_mid_run_idle: outputs %b state %0d, required %b state 0",
               outs(), dbg_state, 8'd0);
    end
    for (int n = 0; n < LATENCY + 4; n++) begin
      @(posedge clk); #1;
      vectors++;
      if (outs() !== 8'd0) begin
        miscompares++;
        $display("FAIL reset_mid_run_quiet: outputs %b, required %b", outs(), 8'd0);
      end
    end
  endtask

  // Random requests issued back to back with random gaps of zero or more idle cycles
  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      logic [31:0] val;
      val = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), val,
             1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        vectors++;
        if (outs() !== 8'd0) begin
          miscompares++;
          $display("FAIL random_gap: outputs %b, required %b", outs(), 8'd0);
        end
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; op_start = 1'b0; op_is_div = 1'b0; op_src_mem = 1'b0;
    mdsrcb_value = 32'd0;
    @(posedge clk); #1;
    test_reset();
    test_mult_reg();
    test_div_mem();
    test_div_zero();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
